// File: rtl/hazard_scoreboard_pkg.sv
// Shared CPU constants for the hazard scoreboard: producer latency codes
// and multiply/divide unit occupancy.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    LAT_NONE = 2'd0,
    LAT_ALU  = 2'd1,
    LAT_LOAD = 2'd2
  } lat_e;

  localparam int LATW_DEFAULT    = 2;
  localparam int MDU_LAT_DEFAULT = 32;

endpackage

// File: rtl/hazard_scoreboard_countdown.sv
// Load/decrement counter: a load overrides the decrement, and the count rests at zero.
module sb_countdown #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard that stalls ID on RAW and HI/LO hazards
// and squashes IF/ID on taken branches and jumps.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int REGW    = $clog2(NREG),
  parameter int LATW    = LATW_DEFAULT,
  parameter int MDU_LAT = MDU_LAT_DEFAULT,
  parameter int CNTW    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_id_valid,
  input  logic [REGW-1:0] i_id_rs,
  input  logic [REGW-1:0] i_id_rt,
  input  logic            i_id_use_rs,
  input  logic            i_id_use_rt,
  input  logic            i_id_early,
  input  logic            i_id_reg_write,
  input  logic [REGW-1:0] i_id_dest,
  input  logic [LATW-1:0] i_id_lat,
  input  logic            i_id_mdu_start,
  input  logic            i_id_mdu_read,
  input  logic            i_branch_taken,
  input  logic            i_jump,
  output logic            o_pc_keep,
  output logic            o_if_id_keep,
  output logic            o_id_ex_flush,
  output logic            o_if_id_flush,
  output logic [NREG-1:0] o_pending,
  output logic            o_mdu_busy,
  output logic [CNTW-1:0] o_stall_cycles
);

  localparam int MDUW = $clog2(MDU_LAT + 1);

  logic [LATW-1:0] w_cnt [NREG];
  logic [MDUW-1:0] w_mdu_cnt;
  logic [LATW-1:0] w_thr;
  logic            w_rs_hazard;
  logic            w_rt_hazard;
  logic            w_mdu_hazard;
  logic            w_stall;
  logic            w_issue;
  logic [CNTW-1:0] r_stall_cnt;

  assign w_cnt[0] = '0;

  // A zero latency or a $0 destination never loads, so a pending count survives it.
  for (genvar g = 1; g < NREG; g++) begin : g_reg
    logic w_load;
    assign w_load = w_issue && i_id_reg_write && (i_id_dest == REGW'(g)) && (i_id_lat != '0);
    sb_countdown #(.W(LATW)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load),
      .i_value (i_id_lat),
      .o_count (w_cnt[g])
    );
  end

  sb_countdown #(.W(MDUW)) u_mdu (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_issue && i_id_mdu_start),
    .i_value (MDUW'(MDU_LAT)),
    .o_count (w_mdu_cnt)
  );

  // Early consumers read in ID, so they need the count fully drained.
  assign w_thr        = i_id_early ? '0 : LATW'(1);
  assign w_rs_hazard  = i_id_use_rs && (w_cnt[i_id_rs] > w_thr);
  assign w_rt_hazard  = i_id_use_rt && (w_cnt[i_id_rt] > w_thr);
  assign w_mdu_hazard = (i_id_mdu_start || i_id_mdu_read) && o_mdu_busy;

  assign w_stall = reset && i_id_valid && (w_rs_hazard || w_rt_hazard || w_mdu_hazard);
  assign w_issue = i_id_valid && !w_stall;

  assign o_pc_keep     = w_stall;
  assign o_if_id_keep  = w_stall;
  assign o_id_ex_flush = w_stall;
  assign o_if_id_flush = reset && w_issue && (i_branch_taken || i_jump);
  assign o_mdu_busy    = (w_mdu_cnt != '0);

  for (genvar r = 0; r < NREG; r++) begin : g_pend
    assign o_pending[r] = (w_cnt[r] != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNTW{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNTW'(1);
    end
  end

  assign o_stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a per-cycle reference model.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int NREG    = 32;
  localparam int REGW    = 5;
  localparam int LATW    = 2;
  localparam int MDU_LAT = 32;
  localparam int CNTW    = 5;
  localparam int CNTMAX  = (1 << CNTW) - 1;

  typedef struct {
    logic            valid;
    logic [REGW-1:0] rs;
    logic [REGW-1:0] rt;
    logic            useRs;
    logic            useRt;
    logic            early;
    logic            regWrite;
    logic [REGW-1:0] dest;
    logic [LATW-1:0] lat;
    logic            mduStart;
    logic            mduRead;
    logic            taken;
    logic            jump;
  } instrT;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            idValid = 1'b0;
  logic [REGW-1:0] idRs = '0;
  logic [REGW-1:0] idRt = '0;
  logic            idUseRs = 1'b0;
  logic            idUseRt = 1'b0;
  logic            idEarly = 1'b0;
  logic            idRegWrite = 1'b0;
  logic [REGW-1:0] idDest = '0;
  logic [LATW-1:0] idLat = '0;
  logic            idMduStart = 1'b0;
  logic            idMduRead = 1'b0;
  logic            branchTaken = 1'b0;
  logic            jump = 1'b0;
  logic            pcKeep;
  logic            ifIdKeep;
  logic            idExFlush;
  logic            ifIdFlush;
  logic [NREG-1:0] pending;
  logic            mduBusy;
  logic [CNTW-1:0] stallCycles;

  int errors = 0;
  int checks = 0;
  int stallSeen = 0;
  int flushSeen = 0;

  // Reference state: remaining cycles per register, MDU occupancy, stall count.
  int modelCnt [NREG];
  int modelMdu = 0;
  int modelStalls = 0;

  hazard_scoreboard #(
    .NREG(NREG), .REGW(REGW), .LATW(LATW), .MDU_LAT(MDU_LAT), .CNTW(CNTW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_id_valid     (idValid),
    .i_id_rs        (idRs),
    .i_id_rt        (idRt),
    .i_id_use_rs    (idUseRs),
    .i_id_use_rt    (idUseRt),
    .i_id_early     (idEarly),
    .i_id_reg_write (idRegWrite),
    .i_id_dest      (idDest),
    .i_id_lat       (idLat),
    .i_id_mdu_start (idMduStart),
    .i_id_mdu_read  (idMduRead),
    .i_branch_taken (branchTaken),
    .i_jump         (jump),
    .o_pc_keep      (pcKeep),
    .o_if_id_keep   (ifIdKeep),
    .o_id_ex_flush  (idExFlush),
    .o_if_id_flush  (ifIdFlush),
    .o_pending      (pending),
    .o_mdu_busy     (mduBusy),
    .o_stall_cycles (stallCycles)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit modelStall();
    int thr;
    bit haz;
    thr = idEarly ? 0 : 1;
    haz = 1'b0;
    if (idUseRs && modelCnt[idRs] > thr) haz = 1'b1;
    if (idUseRt && modelCnt[idRt] > thr) haz = 1'b1;
    if ((idMduStart || idMduRead) && modelMdu > 0) haz = 1'b1;
    return reset && idValid && haz;
  endfunction

  function automatic logic [NREG-1:0] modelPending();
    logic [NREG-1:0] p;
    for (int r = 0; r < NREG; r++) p[r] = (modelCnt[r] != 0);
    return p;
  endfunction

  initial for (int r = 0; r < NREG; r++) modelCnt[r] = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) modelCnt[r] = 0;
      modelMdu = 0;
      modelStalls = 0;
    end else begin
      bit s;
      bit issue;
      s = modelStall();
      issue = idValid && !s;
      for (int r = 0; r < NREG; r++) if (modelCnt[r] > 0) modelCnt[r]--;
      if (issue && idRegWrite && idDest != 0 && idLat != 0) modelCnt[idDest] = int'(idLat);
      if (issue && idMduStart) modelMdu = MDU_LAT;
      else if (modelMdu > 0) modelMdu--;
      if (s && modelStalls < CNTMAX) modelStalls++;
    end
  end

  always @(negedge clk) begin
    bit s;
    s = modelStall();
    checkOutput("pc_keep", 64'(pcKeep), 64'(s));
    checkOutput("if_id_keep", 64'(ifIdKeep), 64'(s));
    checkOutput("id_ex_flush", 64'(idExFlush), 64'(s));
    checkOutput("if_id_flush", 64'(ifIdFlush), 64'(reset && idValid && !s && (branchTaken || jump)));
    checkOutput("pending", 64'(pending), 64'(modelPending()));
    checkOutput("mdu_busy", 64'(mduBusy), 64'(modelMdu > 0));
    checkOutput("stall_cycles", 64'(stallCycles), 64'(modelStalls));
    if (reset && pcKeep) stallSeen++;
    if (reset && ifIdFlush) flushSeen++;
  end

  function automatic instrT makeIns(input int dest, input int lat, input int rs, input bit early,
                                    input bit taken, input bit mduStart, input bit mduRead);
    instrT ins;
    ins.valid    = 1'b1;
    ins.rs       = (rs >= 0) ? REGW'(rs) : '0;
    ins.useRs    = (rs >= 0);
    ins.rt       = '0;
    ins.useRt    = 1'b0;
    ins.early    = early;
    ins.regWrite = (dest >= 0);
    ins.dest     = (dest >= 0) ? REGW'(dest) : '0;
    ins.lat      = LATW'(lat);
    ins.mduStart = mduStart;
    ins.mduRead  = mduRead;
    ins.taken    = taken;
    ins.jump     = 1'b0;
    return ins;
  endfunction

  task automatic drive(input instrT ins);
    idValid = ins.valid; idRs = ins.rs; idRt = ins.rt; idUseRs = ins.useRs; idUseRt = ins.useRt;
    idEarly = ins.early; idRegWrite = ins.regWrite; idDest = ins.dest; idLat = ins.lat;
    idMduStart = ins.mduStart; idMduRead = ins.mduRead; branchTaken = ins.taken; jump = ins.jump;
  endtask

  task automatic idle(input int n);
    idValid = 0; idUseRs = 0; idUseRt = 0; idEarly = 0; idRegWrite = 0; idLat = '0;
    idMduStart = 0; idMduRead = 0; branchTaken = 0; jump = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds the instruction in ID until it issues, bounded so a stuck stall cannot hang the run.
  task automatic applyStimulus(input instrT ins);
    bit stalled;
    drive(ins);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      stalled = pcKeep;
      @(posedge clk);
      #1;
      if (!stalled) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL issue_timeout: instruction still stalled after 200 cycles");
  endtask

  initial begin
    instrT nop;
    nop = makeIns(-1, 0, -1, 0, 0, 0, 0);
    nop.valid = 1'b0;
    drive(nop);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_pending", 64'(pending), 64'd0);
    checkOutput("reset_stall_cycles", 64'(stallCycles), 64'd0);
    reset = 1'b1;
    idle(2);

    // Load to $8 then a dependent add: one stall cycle.
    stallSeen = 0;
    applyStimulus(makeIns(8, LAT_LOAD, -1, 0, 0, 0, 0));
    applyStimulus(makeIns(10, LAT_ALU, 8, 0, 0, 0, 0));
    checkOutput("load_use_stalls", 64'(stallSeen), 64'd1);
    checkOutput("load_use_counter", 64'(stallCycles), 64'd1);
    idle(3);

    // ALU to $8 then a taken beq on $8: one stall, a single flush on issue.
    stallSeen = 0;
    flushSeen = 0;
    applyStimulus(makeIns(8, LAT_ALU, -1, 0, 0, 0, 0));
    applyStimulus(makeIns(-1, 0, 8, 1, 1, 0, 0));
    idle(1);
    checkOutput("alu_branch_stalls", 64'(stallSeen), 64'd1);
    checkOutput("alu_branch_flushes", 64'(flushSeen), 64'd1);
    idle(3);

    // ALU to $8 then a non-early reader: forwarded, no stall.
    stallSeen = 0;
    applyStimulus(makeIns(8, LAT_ALU, -1, 0, 0, 0, 0));
    applyStimulus(makeIns(11, LAT_ALU, 8, 0, 0, 0, 0));
    checkOutput("alu_add_stalls", 64'(stallSeen), 64'd0);
    idle(3);

    // mult, one empty slot, then mflo waits out the rest of the MDU occupancy.
    stallSeen = 0;
    applyStimulus(makeIns(-1, 0, -1, 0, 0, 1, 0));
    idle(1);
    checkOutput("mdu_busy_before_mflo", 64'(mduBusy), 64'd1);
    applyStimulus(makeIns(12, LAT_ALU, -1, 0, 0, 0, 1));
    checkOutput("mflo_stalls", 64'(stallSeen), 64'(MDU_LAT - 1));
    checkOutput("mdu_busy_after_mflo", 64'(mduBusy), 64'd0);
    checkOutput("stall_counter_saturated", 64'(stallCycles), 64'(CNTMAX));
    idle(3);

    // Writes to $0 never become pending.
    stallSeen = 0;
    applyStimulus(makeIns(0, LAT_LOAD, -1, 0, 0, 0, 0));
    checkOutput("r0_pending", 64'(pending), 64'd0);
    applyStimulus(makeIns(13, LAT_ALU, 0, 0, 0, 0, 0));
    checkOutput("r0_reader_stalls", 64'(stallSeen), 64'd0);
    idle(3);

    // A zero-latency write must not clear an in-flight countdown.
    applyStimulus(makeIns(8, LAT_LOAD, -1, 0, 0, 0, 0));
    applyStimulus(makeIns(8, 0, -1, 0, 0, 0, 0));
    checkOutput("lat0_keeps_pending", 64'(pending[8]), 64'd1);
    idle(3);

    // Reset mid-flight with $9 pending clears everything at once.
    applyStimulus(makeIns(9, LAT_LOAD, -1, 0, 0, 0, 0));
    checkOutput("r9_pending", 64'(pending[9]), 64'd1);
    idle(0);
    reset = 1'b0;
    #1;
    checkOutput("midreset_pending", 64'(pending), 64'd0);
    checkOutput("midreset_counter", 64'(stallCycles), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    stallSeen = 0;
    applyStimulus(makeIns(14, LAT_ALU, 9, 0, 0, 0, 0));
    checkOutput("post_reset_r9_stalls", 64'(stallSeen), 64'd0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameters SHALL be: NREG, default 32, architectural register count; REGW, default $clog2(NREG), register index width; LATW, default 2, producer-latency field width; MDU_LAT, default 32, multiply/divide busy cycles; CNTW, default 32, stall-counter width.
REQ-002 The ports SHALL be as follows. Single clock; reset asynchronous, active-low:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- i_id_valid  in  1  ID stage holds a real instruction.
- i_id_rs, i_id_rt  in  REGW  ID source registers.
- i_id_use_rs, i_id_use_rt  in  1  corresponding source is read.
- i_id_early  in  1  ID instruction consumes operands in ID (branch, jr, jalr).
- i_id_reg_write  in  1  ID instruction writes a register.
- i_id_dest  in  REGW  destination register.
- i_id_lat  in  LATW  cycles from issue until the result is forwardable to EX (ALU=1, load=2).
- i_id_mdu_start  in  1  ID instruction starts mult/div.
- i_id_mdu_read  in  1  ID instruction reads HI/LO.
- i_branch_taken  in  1  branch resolved taken in ID.
- i_jump  in  1  unconditional jump in ID.
- o_pc_keep, o_if_id_keep  out  1  hold PC and IF/ID.
- o_id_ex_flush  out  1  insert bubble into ID/EX.
- o_if_id_flush  out  1  squash IF/ID.
- o_pending  out  NREG  bit r set when register r has a nonzero countdown.
- o_mdu_busy  out  1  mult/div unit in flight.
- o_stall_cycles  out  CNTW  saturating count of stall cycles.

Function
REQ-003 The block SHALL hold one LATW-bit countdown cnt[r] per register; cnt[0] SHALL be constant 0.
REQ-004 issue SHALL be defined as i_id_valid AND NOT stall.
REQ-005 Each cycle, every nonzero cnt[r] SHALL decrement by 1, except that on issue with i_id_reg_write=1 and i_id_dest!=0, cnt[i_id_dest] SHALL load i_id_lat; the load overrides the decrement.
REQ-006 The threshold SHALL be 0 when i_id_early=1, else 1; a source hazard exists when a used source register r has cnt[r] > threshold.
REQ-007 The MDU hazard SHALL be (i_id_mdu_start OR i_id_mdu_read) AND o_mdu_busy.
REQ-008 stall SHALL equal i_id_valid AND (source hazard OR MDU hazard), combinationally, from current register state.
REQ-009 o_pc_keep, o_if_id_keep and o_id_ex_flush SHALL all equal stall.
REQ-010 o_if_id_flush SHALL equal (i_branch_taken OR i_jump) AND i_id_valid AND NOT stall; flushes are suppressed during a stall.
REQ-011 On issue with i_id_mdu_start=1, the MDU counter SHALL load MDU_LAT; it otherwise decrements to 0. o_mdu_busy SHALL be counter != 0.
REQ-012 o_stall_cycles SHALL increment once per cycle with stall=1 and saturate at all-ones.
REQ-013 An issue with i_id_lat=0, or with i_id_dest=0, SHALL leave the scoreboard unchanged.
REQ-014 o_pending[r] SHALL equal (cnt[r] != 0), registered state only.

Reset
REQ-015 While reset=0, all cnt, the MDU counter and o_stall_cycles SHALL be 0; all outputs SHALL read 0.
REQ-016 Reset asserted mid-operation SHALL clear pending state immediately; the first cycle after release SHALL see an empty scoreboard.

Structure
REQ-017 Latency encodings (LAT_ALU=1, LAT_LOAD=2) and the MDU_LAT default SHALL live in the shared CPU package.
REQ-018 The block SHALL instantiate one sub-module, sb_countdown (a LATW-bit load/decrement counter), NREG-1 times; the MDU counter uses the same module at its own width.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Load to $8 (lat 2), then add reading $8 -> exactly one stall cycle; o_stall_cycles=1.
- ALU to $8 (lat 1), then beq reading $8 (early) -> one stall, then o_if_id_flush=1 if taken.
- ALU to $8, then non-early add reading $8 -> no stall.
- mult, then mflo at the next instruction -> o_mdu_busy=1; stall for MDU_LAT-1 cycles; issue when busy clears.
- Write to $0 with lat 2, then a read of $0 -> no stall; o_pending=0.
- Reset low while cnt[9]=2 -> o_pending=0 and no stall on a $9 reader after release.
